// File: rtl/quantser_sched.sv
// Round-robin scheduler sharing one quantizer/serializer between NREQ MVU result channels.
// Tracks the serializer shift countdown in lockstep and reports per-channel accept/complete.
module quantser_sched #(
    parameter int NREQ    = 4,
    parameter int BWOUT   = 32,
    parameter int BWBWOUT = $clog2(BWOUT),
    parameter int NREQW   = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*BWBWOUT-1:0]    bwout_req,
    input  logic                       stall,
    output logic                       start,
    output logic [NREQW-1:0]           sel,
    output logic [BWBWOUT-1:0]         bwout,
    output logic [NREQ-1:0]            ack,
    output logic                       busy,
    output logic                       done,
    output logic [NREQW-1:0]           done_id
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    logic [1:0]         r_state;
    logic [NREQW-1:0]   r_sel;
    logic [NREQW-1:0]   r_last;
    logic [BWBWOUT-1:0] r_bwout;
    logic [BWBWOUT-1:0] r_cnt;

    logic               w_found;
    logic [NREQW-1:0]   w_win;
    logic [BWBWOUT-1:0] w_winBw;
    logic               w_accept;
    logic               w_done;
    logic               w_arb;

    // Search from the channel after the last grant; lowest offset wins, so scan offsets downward.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_winBw = '0;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = (int'(r_last) + k) % NREQ;
            if (req[idx]) begin
                w_found = 1'b1;
                w_win   = NREQW'(idx);
                w_winBw = bwout_req[idx*BWBWOUT +: BWBWOUT];
            end
        end
    end

    assign w_accept = (r_state == S_LOAD) && !stall;
    assign w_done   = (w_accept && (r_bwout == '0)) ||
                      ((r_state == S_SHIFT) && !stall && (r_cnt == BWBWOUT'(1)));
    assign w_arb    = (r_state == S_IDLE) || w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_bwout <= '0;
            r_cnt   <= '0;
            r_last  <= NREQW'(NREQ - 1);
        end else begin
            if (w_arb) begin
                if (w_found) begin
                    r_sel   <= w_win;
                    r_bwout <= w_winBw;
                    r_last  <= w_win;
                    r_state <= S_LOAD;
                end else begin
                    r_state <= S_IDLE;
                end
            end else if (w_accept) begin
                r_state <= S_SHIFT;
            end

            if (w_accept) begin
                r_cnt <= r_bwout;
            end else if ((r_state == S_SHIFT) && !stall) begin
                r_cnt <= r_cnt - BWBWOUT'(1);
            end
        end
    end

    always_comb begin
        ack = '0;
        if (w_accept) begin
            ack[r_sel] = 1'b1;
        end
    end

    assign start   = (r_state == S_LOAD);
    assign busy    = (r_state != S_IDLE);
    assign done    = w_done;
    assign done_id = r_sel;
    assign sel     = r_sel;
    assign bwout   = r_bwout;

endmodule

// File: tb/tb_quantser_sched.sv
// Scoreboard bench for quantser_sched: a word-level reference model queues expected
// accepts, completions and per-cycle status; a negedge monitor pops and compares.
module tb_quantser_sched;

    localparam int NREQ    = 4;
    localparam int BWOUT   = 32;
    localparam int BWBWOUT = 5;
    localparam int NREQW   = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NREQ-1:0]         req;
    logic [NREQ*BWBWOUT-1:0] bwout_req;
    logic                    stall;
    logic                    start;
    logic [NREQW-1:0]        sel;
    logic [BWBWOUT-1:0]      bwout;
    logic [NREQ-1:0]         ack;
    logic                    busy;
    logic                    done;
    logic [NREQW-1:0]        done_id;

    quantser_sched #(.NREQ(NREQ), .BWOUT(BWOUT), .BWBWOUT(BWBWOUT), .NREQW(NREQW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .bwout_req(bwout_req), .stall(stall),
        .start(start), .sel(sel), .bwout(bwout), .ack(ack), .busy(busy),
        .done(done), .done_id(done_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int chan;
        int bw;
    } event_t;

    typedef struct {
        int cyc;
        int busy;
        int start;
        int sel;
        int bw;
    } status_t;

    event_t  ackQ[$];
    event_t  doneQ[$];
    status_t statusQ[$];

    int nCompared   = 0;
    int nMismatched = 0;
    int cycleCnt    = 0;

    // Word-level reference model state
    int mActive, mAccepted, mSel, mBw, mLast, mRemain;
    int mAckedNow[NREQ];

    // Random requester state
    int rqOn[NREQ];
    int rqBw[NREQ];

    task automatic checkOutput(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycleCnt, act, exp);
        end
    endtask

    function automatic int pickNext(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ*BWBWOUT-1:0] bwPack(input int b0, input int b1, input int b2, input int b3);
        logic [NREQ*BWBWOUT-1:0] v;
        v = '0;
        v[0*BWBWOUT +: BWBWOUT] = BWBWOUT'(b0);
        v[1*BWBWOUT +: BWBWOUT] = BWBWOUT'(b1);
        v[2*BWBWOUT +: BWBWOUT] = BWBWOUT'(b2);
        v[3*BWBWOUT +: BWBWOUT] = BWBWOUT'(b3);
        return v;
    endfunction

    function automatic int newBw();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, BWOUT - 1));
        return int'($urandom_range(0, 4));
    endfunction

    task automatic modelReset();
        mActive = 0; mAccepted = 0; mSel = 0; mBw = 0; mLast = NREQ - 1; mRemain = 0;
        for (int i = 0; i < NREQ; i++) begin
            mAckedNow[i] = 0; rqOn[i] = 0; rqBw[i] = 0;
        end
        ackQ.delete(); doneQ.delete(); statusQ.delete();
    endtask

    task automatic modelGrant(input logic [NREQ-1:0] r, input logic [NREQ*BWBWOUT-1:0] b);
        int c;
        c = pickNext(r, mLast);
        mActive = 0;
        if (c >= 0) begin
            mActive = 1; mAccepted = 0; mSel = c; mLast = c;
            mBw = int'(b[c*BWBWOUT +: BWBWOUT]);
        end
    endtask

    task automatic modelComplete(input logic [NREQ-1:0] r, input logic [NREQ*BWBWOUT-1:0] b);
        doneQ.push_back('{cyc: cycleCnt, chan: mSel, bw: mBw});
        modelGrant(r, b);
    endtask

    // One clock of the reference: outputs for this cycle come from the word in progress.
    task automatic modelStep(input logic [NREQ-1:0] r, input logic [NREQ*BWBWOUT-1:0] b, input logic st);
        for (int i = 0; i < NREQ; i++) mAckedNow[i] = 0;
        statusQ.push_back('{cyc: cycleCnt, busy: mActive, start: (mActive != 0 && mAccepted == 0) ? 1 : 0,
                           sel: mSel, bw: mBw});
        if (mActive == 0) begin
            modelGrant(r, b);
        end else if (mAccepted == 0) begin
            if (!st) begin
                ackQ.push_back('{cyc: cycleCnt, chan: mSel, bw: mBw});
                mAckedNow[mSel] = 1;
                mAccepted = 1;
                mRemain = mBw;
                if (mBw == 0) modelComplete(r, b);
            end
        end else if (!st) begin
            if (mRemain == 1) modelComplete(r, b);
            else mRemain--;
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*BWBWOUT-1:0] b, input logic st);
        req = r; bwout_req = b; stall = st;
        modelStep(r, b, st);
        @(posedge clk);
        #1;
        cycleCnt++;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req = '0; stall = 1'b0;
        #2;
        checkOutput("rst_start", int'(start), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_ack", int'(ack), 0);
        checkOutput("rst_sel", int'(sel), 0);
        checkOutput("rst_bwout", int'(bwout), 0);
        checkOutput("rst_done_id", int'(done_id), 0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (statusQ.size() > 0) begin
                status_t s;
                s = statusQ.pop_front();
                checkOutput("busy", int'(busy), s.busy);
                checkOutput("start", int'(start), s.start);
                checkOutput("sel", int'(sel), s.sel);
                checkOutput("bwout", int'(bwout), s.bw);
            end
            if (ack != '0) begin
                if (ackQ.size() == 0) begin
                    checkOutput("ack_unexpected", int'(ack), 0);
                end else begin
                    event_t e;
                    e = ackQ.pop_front();
                    checkOutput("ack_cycle", cycleCnt, e.cyc);
                    checkOutput("ack_vec", int'(ack), 1 << e.chan);
                end
            end else if (ackQ.size() > 0 && ackQ[0].cyc <= cycleCnt) begin
                event_t e;
                e = ackQ.pop_front();
                checkOutput("ack_missing", int'(ack), 1 << e.chan);
            end
            if (done) begin
                if (doneQ.size() == 0) begin
                    checkOutput("done_unexpected", int'(done), 0);
                end else begin
                    event_t e;
                    e = doneQ.pop_front();
                    checkOutput("done_cycle", cycleCnt, e.cyc);
                    checkOutput("done_id", int'(done_id), e.chan);
                end
            end else if (doneQ.size() > 0 && doneQ[0].cyc <= cycleCnt) begin
                event_t e;
                e = doneQ.pop_front();
                checkOutput("done_missing", int'(done), 1);
            end
        end
    end

    initial begin
        logic [NREQ-1:0]         r;
        logic [NREQ*BWBWOUT-1:0] b;
        logic [2:0]              stallSeq;

        rst_n = 1'b1; req = '0; bwout_req = '0; stall = 1'b0;
        #1;
        doReset();

        // Single word, bwout=3
        b = bwPack(3, 0, 0, 0);
        applyStimulus(4'b0001, b, 1'b0);
        applyStimulus(4'b0001, b, 1'b0);
        repeat (5) applyStimulus(4'b0000, b, 1'b0);

        // All channels, zero-length words back to back
        b = bwPack(0, 0, 0, 0);
        repeat (8) applyStimulus(4'b1111, b, 1'b0);
        repeat (3) applyStimulus(4'b0000, b, 1'b0);

        // Stalls in LOAD and in SHIFT
        b = bwPack(0, 2, 0, 0);
        stallSeq = 3'b110;
        for (int i = 0; i < 4; i++) applyStimulus(4'b0010, b, (i == 1 || i == 2) ? 1'b1 : 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, b, stallSeq[2 - i] & (i == 0));
        repeat (3) applyStimulus(4'b0000, b, 1'b0);

        // Two channels alternating with bwout=1
        b = bwPack(1, 0, 1, 0);
        repeat (9) applyStimulus(4'b0101, b, 1'b0);
        repeat (4) applyStimulus(4'b0000, b, 1'b0);

        // Reset in the middle of SHIFT, then pointer restart check
        b = bwPack(0, 0, 0, 5);
        repeat (4) applyStimulus(4'b1000, b, 1'b0);
        doReset();
        b = bwPack(0, 0, 1, 1);
        repeat (6) applyStimulus(4'b1100, b, 1'b0);
        repeat (4) applyStimulus(4'b0000, b, 1'b0);

        // One-cycle request pulse still completes
        b = bwPack(0, 0, 0, 2);
        applyStimulus(4'b1000, b, 1'b0);
        repeat (5) applyStimulus(4'b0000, b, 1'b0);

        // Randomized traffic with stalls
        for (int i = 0; i < NREQ; i++) begin
            rqOn[i] = 0; rqBw[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (mAckedNow[i] != 0) begin
                    if ($urandom_range(0, 3) == 0) rqBw[i] = newBw();
                    else rqOn[i] = 0;
                end else if (rqOn[i] == 0 && $urandom_range(0, 3) == 0) begin
                    rqOn[i] = 1;
                    rqBw[i] = newBw();
                end
            end
            for (int i = 0; i < NREQ; i++) r[i] = (rqOn[i] != 0);
            b = bwPack(rqBw[0], rqBw[1], rqBw[2], rqBw[3]);
            applyStimulus(r, b, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end
        repeat (40) applyStimulus(4'b0000, b, 1'b0);

        checkOutput("ack_queue_drained", ackQ.size(), 0);
        checkOutput("done_queue_drained", doneQ.size(), 0);
        checkOutput("idle_at_end", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
